// File: rtl/crown_finish_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crown_finish_ctrl : last-level crown gating, touch detect, blink, win and  |
// | restart handshake. Option macro: CROWN_AUTO_RESTART_EN (timed restart).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module crown_finish_ctrl #(
  parameter int MAX_LEVEL     = 4,
  parameter int FINISH_X_LEFT = 500,
  parameter int FINISH_Y_UP   = 100,
  parameter int CROWN_W       = 64,
  parameter int CROWN_H       = 48,
  parameter int CHAR_W        = 32,
  parameter int CHAR_H        = 32,
  parameter int HIT_FRAMES    = 4,
  parameter int FLASH_PERIOD  = 8,
  parameter int FLASH_TOGGLES = 6,
  parameter int WON_FRAMES    = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [1:0]  level,
  input  logic [10:0] char_x,
  input  logic [10:0] char_y,
  input  logic        btn_start,
  input  logic        restart_ack,
  output logic        crown_en,
  output logic        game_won,
  output logic        restart_req
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHOW  = 3'd1;
  localparam logic [2:0] S_FLASH = 3'd2;
  localparam logic [2:0] S_WON   = 3'd3;
  localparam logic [2:0] S_REQ   = 3'd4;

  // One frame counter serves both the blink period and the WON dwell.
  localparam int C_FRAME_MAX = (FLASH_PERIOD > WON_FRAMES) ? FLASH_PERIOD : WON_FRAMES;
  localparam int C_FRAME_W   = $clog2(C_FRAME_MAX + 1);
  localparam int C_HIT_W     = $clog2(HIT_FRAMES + 1);
  localparam int C_TOG_W     = $clog2(FLASH_TOGGLES + 1);

  localparam logic [C_HIT_W-1:0]   C_HIT_LAST   = C_HIT_W'(HIT_FRAMES - 1);
  localparam logic [C_FRAME_W-1:0] C_FLASH_LAST = C_FRAME_W'(FLASH_PERIOD - 1);
  localparam logic [C_TOG_W-1:0]   C_TOG_LAST   = C_TOG_W'(FLASH_TOGGLES - 1);
  localparam logic [1:0]           C_CROWN_LVL  = 2'(MAX_LEVEL - 1);

  localparam logic [11:0] C_X_LEFT  = 12'(FINISH_X_LEFT);
  localparam logic [11:0] C_X_RIGHT = 12'(FINISH_X_LEFT + CROWN_W);
  localparam logic [11:0] C_Y_UP    = 12'(FINISH_Y_UP);
  localparam logic [11:0] C_Y_DOWN  = 12'(FINISH_Y_UP + CROWN_H);
  localparam logic [11:0] C_CHAR_W  = 12'(CHAR_W);
  localparam logic [11:0] C_CHAR_H  = 12'(CHAR_H);

  logic [2:0]           r_state;
  logic                 r_vsync_q;
  logic [C_HIT_W-1:0]   r_hit_cnt;
  logic [C_FRAME_W-1:0] r_frame_cnt;
  logic [C_TOG_W-1:0]   r_tog_cnt;
  logic                 r_crown_en;
  logic                 r_game_won;
  logic                 r_restart_req;

  logic w_tick;
  logic w_overlap;
  logic w_level_ok;
  logic w_restart_go;

  assign w_tick     = vsync & ~r_vsync_q;
  assign w_level_ok = (level == C_CROWN_LVL);

  // Sums are one bit wider than the coordinates so a box near 2047 cannot wrap.
  assign w_overlap = ({1'b0, char_x} < C_X_RIGHT) &&
                     (({1'b0, char_x} + C_CHAR_W) > C_X_LEFT) &&
                     ({1'b0, char_y} < C_Y_DOWN) &&
                     (({1'b0, char_y} + C_CHAR_H) > C_Y_UP);

`ifdef CROWN_AUTO_RESTART_EN
  localparam logic [C_FRAME_W-1:0] C_WON_LAST = C_FRAME_W'(WON_FRAMES - 1);
  assign w_restart_go = w_tick && (r_frame_cnt >= C_WON_LAST);
`else
  logic r_btn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= btn_start;
    end
  end

  assign w_restart_go = btn_start & ~r_btn_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_vsync_q     <= 1'b0;
      r_hit_cnt     <= '0;
      r_frame_cnt   <= '0;
      r_tog_cnt     <= '0;
      r_crown_en    <= 1'b0;
      r_game_won    <= 1'b0;
      r_restart_req <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      case (r_state)
        S_IDLE: begin
          r_hit_cnt     <= '0;
          r_frame_cnt   <= '0;
          r_tog_cnt     <= '0;
          r_crown_en    <= 1'b0;
          r_game_won    <= 1'b0;
          r_restart_req <= 1'b0;
          if (w_level_ok) begin
            r_state    <= S_SHOW;
            r_crown_en <= 1'b1;
          end
        end

        S_SHOW: begin
          if (!w_level_ok) begin
            r_state     <= S_IDLE;
            r_hit_cnt   <= '0;
            r_frame_cnt <= '0;
            r_tog_cnt   <= '0;
            r_crown_en  <= 1'b0;
            r_game_won  <= 1'b0;
          end else if (w_tick) begin
            if (!w_overlap) begin
              r_hit_cnt <= '0;
            end else if (r_hit_cnt >= C_HIT_LAST) begin
              r_state     <= S_FLASH;
              r_hit_cnt   <= '0;
              r_frame_cnt <= '0;
              r_tog_cnt   <= '0;
              r_crown_en  <= 1'b1;
              r_game_won  <= 1'b1;
            end else begin
              r_hit_cnt <= r_hit_cnt + 1'b1;
            end
          end
        end

        S_FLASH: begin
          if (!w_level_ok) begin
            r_state     <= S_IDLE;
            r_hit_cnt   <= '0;
            r_frame_cnt <= '0;
            r_tog_cnt   <= '0;
            r_crown_en  <= 1'b0;
            r_game_won  <= 1'b0;
          end else if (w_tick) begin
            if (r_frame_cnt >= C_FLASH_LAST) begin
              r_frame_cnt <= '0;
              if (r_tog_cnt >= C_TOG_LAST) begin
                r_state    <= S_WON;
                r_tog_cnt  <= '0;
                r_crown_en <= 1'b1;
              end else begin
                r_tog_cnt  <= r_tog_cnt + 1'b1;
                r_crown_en <= ~r_crown_en;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end

        S_WON: begin
          r_crown_en <= 1'b1;
          r_game_won <= 1'b1;
          if (w_restart_go) begin
            r_state       <= S_REQ;
            r_frame_cnt   <= '0;
            r_restart_req <= 1'b1;
          end else if (w_tick && (r_frame_cnt < C_FRAME_W'(C_FRAME_MAX))) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
          end
        end

        S_REQ: begin
          if (restart_ack) begin
            r_state       <= S_IDLE;
            r_restart_req <= 1'b0;
            r_game_won    <= 1'b0;
            r_crown_en    <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign crown_en    = r_crown_en;
  assign game_won    = r_game_won;
  assign restart_req = r_restart_req;

endmodule
`default_nettype wire

// File: tb/tb_crown_finish_ctrl.sv
`default_nettype none
// Bench for crown_finish_ctrl: directed scenarios plus randomized character paths
// checked against an arithmetic model of the finish rules.
module tb_crown_finish_ctrl;

  localparam int BOX_L   = 500;
  localparam int BOX_T   = 100;
  localparam int BOX_W   = 64;
  localparam int BOX_H   = 48;
  localparam int CW      = 32;
  localparam int CH      = 32;
  localparam int HITS    = 4;
  localparam int PERIOD  = 8;
  localparam int TOGGLES = 6;
  localparam int WONF    = 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic [1:0]  level = 2'd0;
  logic [10:0] char_x = '0;
  logic [10:0] char_y = '0;
  logic        btn_start = 1'b0;
  logic        restart_ack = 1'b0;
  logic        crown_en;
  logic        game_won;
  logic        restart_req;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  crown_finish_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .level(level),
    .char_x(char_x), .char_y(char_y), .btn_start(btn_start),
    .restart_ack(restart_ack), .crown_en(crown_en),
    .game_won(game_won), .restart_req(restart_req)
  );

  function automatic bit model_overlap(int x, int y);
    return (x < BOX_L + BOX_W) && (x + CW > BOX_L) && (y < BOX_T + BOX_H) && (y + CH > BOX_T);
  endfunction

  // Crown enable k ticks after the win was declared.
  function automatic bit model_flash_en(int k);
    int t;
    t = k / PERIOD;
    if (t >= TOGGLES) return 1'b1;
    return (t % 2) == 0;
  endfunction

  task automatic frame();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic start_show();
    rst = 1'b1; level = 2'd3; char_x = 11'd0; char_y = 11'd0;
    btn_start = 1'b0; restart_ack = 1'b0; vsync = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic enter_flash();
    start_show();
    char_x = 11'd480; char_y = 11'd110;
    repeat (HITS) frame();
    char_x = 11'd0; char_y = 11'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (crown_en !== 1'b0) begin n_bad++; $display("FAIL reset_crown_en got=%b want=0", crown_en); end
    n_cmp++; if (game_won !== 1'b0) begin n_bad++; $display("FAIL reset_game_won got=%b want=0", game_won); end
    n_cmp++; if (restart_req !== 1'b0) begin n_bad++; $display("FAIL reset_restart_req got=%b want=0", restart_req); end
  endtask

  task automatic test_wrong_level();
    bit got;
    rst = 1'b0; level = 2'd2; char_x = 11'd480; char_y = 11'd110;
    for (int f = 0; f < 10; f++) begin
      frame();
      n_cmp++; if (crown_en !== 1'b0 || game_won !== 1'b0) begin
        n_bad++; $display("FAIL wrong_level frame=%0d got crown_en=%b game_won=%b want 0/0", f, crown_en, game_won);
      end
    end
    char_x = 11'd0; char_y = 11'd0; level = 2'd3;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      @(negedge clk);
      got = crown_en;
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL show_enable got=%b want=1 within 2 clk", got); end
  endtask

  task automatic test_flash_sequence();
    start_show();
    char_x = 11'd480; char_y = 11'd110;
    for (int f = 1; f <= HITS; f++) begin
      frame();
      n_cmp++; if (game_won !== (f == HITS) || crown_en !== 1'b1) begin
        n_bad++; $display("FAIL hit_frame=%0d got won=%b en=%b want won=%b en=1", f, game_won, crown_en, f == HITS);
      end
    end
    char_x = 11'd0; char_y = 11'd0;
    for (int k = 1; k <= PERIOD * TOGGLES; k++) begin
      frame();
      n_cmp++; if (crown_en !== model_flash_en(k) || game_won !== 1'b1) begin
        n_bad++; $display("FAIL flash_tick=%0d got en=%b won=%b want en=%b won=1", k, crown_en, game_won, model_flash_en(k));
      end
    end
  endtask

  // Continues from WON left by test_flash_sequence; also covers a level change during REQ.
  task automatic test_restart();
`ifdef CROWN_AUTO_RESTART_EN
    for (int j = 1; j <= WONF; j++) begin
      frame();
      n_cmp++; if (restart_req !== (j >= WONF)) begin
        n_bad++; $display("FAIL won_tick=%0d got req=%b want=%b", j, restart_req, j >= WONF);
      end
    end
`else
    for (int j = 0; j < 5; j++) begin
      frame();
      n_cmp++; if (restart_req !== 1'b0 || game_won !== 1'b1 || crown_en !== 1'b1) begin
        n_bad++; $display("FAIL won_wait=%0d got req=%b won=%b en=%b want 0/1/1", j, restart_req, game_won, crown_en);
      end
    end
    btn_start = 1'b1;
    @(negedge clk);
    n_cmp++; if (restart_req !== 1'b1) begin n_bad++; $display("FAIL btn_rise_req got=%b want=1", restart_req); end
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (restart_req !== 1'b1) begin n_bad++; $display("FAIL req_hold clk=%0d got=%b want=1", i, restart_req); end
    end
    level = 2'd1;
    frame();
    n_cmp++; if (restart_req !== 1'b1) begin n_bad++; $display("FAIL req_level_change got=%b want=1", restart_req); end
    btn_start = 1'b0;
    restart_ack = 1'b1;
    @(negedge clk);
    restart_ack = 1'b0;
    n_cmp++; if (restart_req !== 1'b0 || game_won !== 1'b0 || crown_en !== 1'b0) begin
      n_bad++; $display("FAIL ack_release got req=%b won=%b en=%b want 0/0/0", restart_req, game_won, crown_en);
    end
    frame();
    n_cmp++; if (crown_en !== 1'b0 || restart_req !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_ack got en=%b req=%b want 0/0", crown_en, restart_req);
    end
  endtask

  task automatic test_level_change();
    enter_flash();
    repeat (3) frame();
    level = 2'd1;
    @(negedge clk);
    n_cmp++; if (crown_en !== 1'b0 || game_won !== 1'b0) begin
      n_bad++; $display("FAIL flash_leave got en=%b won=%b want 0/0", crown_en, game_won);
    end
    repeat (2) frame();
    n_cmp++; if (crown_en !== 1'b0 || game_won !== 1'b0) begin
      n_bad++; $display("FAIL flash_leave_hold got en=%b won=%b want 0/0", crown_en, game_won);
    end
    // Last qualifying tick coincides with the level drop: the drop must win.
    start_show();
    char_x = 11'd480; char_y = 11'd110;
    repeat (HITS - 1) frame();
    level = 2'd1; vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    n_cmp++; if (crown_en !== 1'b0 || game_won !== 1'b0) begin
      n_bad++; $display("FAIL tick_vs_level got en=%b won=%b want 0/0", crown_en, game_won);
    end
  endtask

  task automatic test_hit_clear();
    start_show();
    for (int f = 0; f < 7; f++) begin
      if (f == 3) begin char_x = 11'd0; char_y = 11'd0; end
      else begin char_x = 11'd480; char_y = 11'd110; end
      frame();
      n_cmp++; if (game_won !== 1'b0) begin n_bad++; $display("FAIL hit_clear frame=%0d got won=%b want 0", f, game_won); end
    end
    frame();
    n_cmp++; if (game_won !== 1'b1) begin n_bad++; $display("FAIL hit_clear_final got won=%b want 1", game_won); end
  endtask

  task automatic test_reset_mid_flash();
    bit got;
    enter_flash();
    repeat (5) frame();
    n_cmp++; if (game_won !== 1'b1) begin n_bad++; $display("FAIL pre_reset_flash got won=%b want 1", game_won); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (crown_en !== 1'b0 || game_won !== 1'b0 || restart_req !== 1'b0) begin
      n_bad++; $display("FAIL async_reset got en=%b won=%b req=%b want 0/0/0", crown_en, game_won, restart_req);
    end
    #4 rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2 && !got; i++) begin
      @(posedge clk);
      #1 got = crown_en;
    end
    n_cmp++; if (got !== 1'b1 || game_won !== 1'b0) begin
      n_bad++; $display("FAIL after_reset got en=%b won=%b want 1/0", got, game_won);
    end
    @(negedge clk);
  endtask

  task automatic test_boundaries();
    int xs [9] = '{468, 469, 563, 564, 480, 480, 480, 480, 2040};
    int ys [9] = '{110, 110, 110, 110, 68, 69, 147, 148, 2040};
    for (int i = 0; i < 9; i++) begin
      start_show();
      char_x = 11'(xs[i]); char_y = 11'(ys[i]);
      repeat (HITS) frame();
      n_cmp++; if (game_won !== model_overlap(xs[i], ys[i])) begin
        n_bad++; $display("FAIL boundary x=%0d y=%0d got won=%b want %b", xs[i], ys[i], game_won, model_overlap(xs[i], ys[i]));
      end
    end
  endtask

  task automatic test_random_paths();
    for (int r = 0; r < 6; r++) begin
      int run;
      bit won;
      start_show();
      run = 0; won = 1'b0;
      for (int f = 0; f < 40 && !won; f++) begin
        int x, y;
        if ($urandom_range(0, 9) < 3) begin
          x = $urandom_range(BOX_L - CW + 1, BOX_L + BOX_W - 1);
          y = $urandom_range(BOX_T - CH + 1, BOX_T + BOX_H - 1);
        end else begin
          x = $urandom_range(440, 600);
          y = $urandom_range(40, 190);
        end
        char_x = 11'(x); char_y = 11'(y);
        run = model_overlap(x, y) ? run + 1 : 0;
        won = (run >= HITS);
        frame();
        n_cmp++; if (game_won !== won || crown_en !== 1'b1) begin
          n_bad++; $display("FAIL random r=%0d f=%0d x=%0d y=%0d got won=%b en=%b want won=%b en=1", r, f, x, y, game_won, crown_en, won);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrong_level();
    test_flash_sequence();
    test_restart();
    test_level_change();
    test_hit_clear();
    test_reset_mid_flash();
    test_boundaries();
    test_random_paths();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
